// File: rtl/led_sw_sequencer.sv
// -----------------------------------------------------------------------------
// led_sw_sequencer
//   Debounces eight board switches and uses the debounced vector to drive a
//   four-LED pattern sequencer (static / binary count / walking one / blink).
//
//   Switch field decode (debounced vector):
//     [1:0] requested mode   [2] pause   [3] direction (1 = down/right)
//     [7:4] pattern data
//
// Ports
//   clk_100MHz    in   single clock, rising edge
//   reset         in   synchronous, active-high
//   switch_tri_i  in   [7:0] raw asynchronous switches
//   led_tri_o     out  [3:0] registered LED drive
//   sw_stable_o   out  [7:0] registered debounced switch vector
//   mode_o        out  [1:0] current sequencer state (registered)
// -----------------------------------------------------------------------------
module led_sw_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 25000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [7:0] switch_tri_i,
    output logic [3:0] led_tri_o,
    output logic [7:0] sw_stable_o,
    output logic [1:0] mode_o
);

    typedef enum logic [1:0] {
        ST_STATIC = 2'b00,
        ST_COUNT  = 2'b01,
        ST_SHIFT  = 2'b10,
        ST_BLINK  = 2'b11
    } state_t;

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] TK_LAST = 26'(TICK_CYCLES - 1);

    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_cand;
    logic [7:0]  r_stable;
    logic [23:0] r_dbcnt;
    logic [25:0] r_presc;
    logic        r_phase;
    logic [3:0]  r_led;
    state_t      r_state;

    state_t      w_state_nxt;
    logic [3:0]  w_led_nxt;
    logic        w_phase_nxt;
    logic [23:0] w_db_inc;
    logic [1:0]  w_req;
    logic        w_pause;
    logic        w_dir;
    logic [3:0]  w_data;
    logic        w_mode_chg;
    logic        w_tick;

    assign w_req      = r_stable[1:0];
    assign w_pause    = r_stable[2];
    assign w_dir      = r_stable[3];
    assign w_data     = r_stable[7:4];
    assign w_db_inc   = r_dbcnt + 24'd1;
    assign w_mode_chg = (w_req != r_state);
    assign w_tick     = (r_presc == TK_LAST) && !w_pause;

    // Synchronizer + debounce. The candidate is reloaded whenever the
    // synchronized input moves, so only an input held for DEBOUNCE_CYCLES
    // consecutive clocks reaches r_stable.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_dbcnt  <= '0;
            r_stable <= '0;
        end else begin
            r_sync1 <= switch_tri_i;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand  <= r_sync2;
                r_dbcnt <= '0;
            end else if (r_cand != r_stable) begin
                // Compare the incremented value so acceptance lands exactly
                // DEBOUNCE_CYCLES clocks after sync first shows the new value.
                if (w_db_inc == DB_LAST) begin
                    r_stable <= r_cand;
                    r_dbcnt  <= '0;
                end else begin
                    r_dbcnt <= w_db_inc;
                end
            end
        end
    end

    // Step prescaler: restarts on every mode change so the first step of a
    // new pattern is a full period away; frozen while paused.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_mode_chg) begin
            r_presc <= '0;
        end else if (!w_pause) begin
            if (r_presc == TK_LAST) r_presc <= '0;
            else                    r_presc <= r_presc + 26'd1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= ST_STATIC;
            r_led   <= 4'b0000;
            r_phase <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Mode change wins over a coincident tick: the entry load replaces
    // whatever the tick would have done.
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_phase_nxt = r_phase;
        if (w_mode_chg) begin
            w_state_nxt = state_t'(w_req);
            case (state_t'(w_req))
                ST_STATIC: w_led_nxt = w_data;
                ST_COUNT:  w_led_nxt = 4'b0000;
                ST_SHIFT:  w_led_nxt = 4'b0001;
                ST_BLINK: begin
                    w_phase_nxt = 1'b1;
                    w_led_nxt   = w_data;
                end
                default: ;
            endcase
        end else begin
            case (r_state)
                ST_STATIC: w_led_nxt = w_data;
                ST_COUNT: begin
                    if (w_tick) w_led_nxt = w_dir ? (r_led - 4'd1) : (r_led + 4'd1);
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        // Recover from a corrupted (non one-hot) pattern.
                        if (!$onehot(r_led)) w_led_nxt = 4'b0001;
                        else if (w_dir)      w_led_nxt = {r_led[0], r_led[3:1]};
                        else                 w_led_nxt = {r_led[2:0], r_led[3]};
                    end
                end
                ST_BLINK: begin
                    // Data follows the switches live during the on phase.
                    if (w_tick) begin
                        w_phase_nxt = ~r_phase;
                        w_led_nxt   = r_phase ? 4'b0000 : w_data;
                    end else begin
                        w_led_nxt   = r_phase ? w_data : 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign led_tri_o   = r_led;
    assign sw_stable_o = r_stable;
    assign mode_o      = r_state;

endmodule

// File: tb/tb_led_sw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sw_sequencer
//   Directed scenarios followed by randomized switch activity. A behavioural
//   model (input run-length debounce, arithmetic pattern steps) predicts every
//   output on every clock; key scenario points are also checked against
//   hand-derived constants.
// -----------------------------------------------------------------------------
module tb_led_sw_sequencer;

    localparam int D = 4;
    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [3:0] led;
    logic [7:0] stab;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [7:0] m_s1, m_s2, m_last, m_stable;
    int         m_run, m_cnt;
    logic       m_on;
    logic [1:0] m_mode;
    logic [3:0] m_led;

    always #5 clk = ~clk;

    led_sw_sequencer #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
        .clk_100MHz  (clk),
        .reset       (rst),
        .switch_tri_i(sw),
        .led_tri_o   (led),
        .sw_stable_o (stab),
        .mode_o      (mode)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model, using values seen before the edge.
    task automatic model_step(input logic [7:0] s, input logic r);
        logic [1:0] req;
        logic       pause, dir, tick;
        logic [3:0] data;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_last = 0; m_run = 1; m_stable = 0;
            m_cnt = 0; m_on = 1; m_mode = 0; m_led = 0;
        end else begin
            req   = m_stable[1:0];
            pause = m_stable[2];
            dir   = m_stable[3];
            data  = m_stable[7:4];
            tick  = (m_cnt == T - 1) && !pause;
            if (req != m_mode) begin
                m_mode = req;
                m_cnt  = 0;
                case (req)
                    2'd0: m_led = data;
                    2'd1: m_led = 0;
                    2'd2: m_led = 1;
                    default: begin m_on = 1; m_led = data; end
                endcase
            end else begin
                if (!pause) m_cnt = (m_cnt + 1) % T;
                case (m_mode)
                    2'd0: m_led = data;
                    2'd1: if (tick) m_led = 4'((int'(m_led) + (dir ? 15 : 1)) % 16);
                    2'd2: if (tick) begin
                        if ($countones(m_led) != 1) m_led = 1;
                        else if (dir) m_led = 4'(int'(m_led) / 2 + (int'(m_led) % 2) * 8);
                        else          m_led = 4'((int'(m_led) * 2) % 16 + int'(m_led) / 8);
                    end
                    default: begin
                        if (tick) m_on = !m_on;
                        m_led = m_on ? data : 4'd0;
                    end
                endcase
            end
            // Accept a synchronized value the clock its run reaches D.
            if (m_s2 == m_last) m_run++;
            else begin m_run = 1; m_last = m_s2; end
            if (m_run == D && m_s2 != m_stable) m_stable = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
        end
    endtask

    task automatic step(input logic [7:0] s, input logic r);
        sw  = s;
        rst = r;
        @(posedge clk);
        model_step(s, r);
        #1;
        check("model_led",    {4'd0, led},  {4'd0, m_led});
        check("model_stable", stab,         m_stable);
        check("model_mode",   {6'd0, mode}, {6'd0, m_mode});
    endtask

    task automatic cyc(input logic [7:0] s);
        step(s, 1'b0);
    endtask

    task automatic hold(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(s);
    endtask

    initial begin
        int n;
        logic [7:0] rs;
        sw  = 8'h00;
        rst = 1'b1;
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        check("rst_led",    {4'd0, led},  8'h00);
        check("rst_stable", stab,         8'h00);
        check("rst_mode",   {6'd0, mode}, 8'h00);

        // glitch shorter than the debounce window
        hold(8'h04, 3);
        hold(8'h00, 10);
        check("glitch_stable", stab,        8'h00);
        check("glitch_led",    {4'd0, led}, 8'h00);

        // debounce accept after exactly 2+D clocks
        hold(8'hA0, 5);
        check("db_early", stab, 8'h00);
        cyc(8'hA0);
        check("db_accept", stab, 8'hA0);
        cyc(8'hA0);
        check("static_led",  {4'd0, led},  8'h0A);
        check("static_mode", {6'd0, mode}, 8'h00);

        // COUNT down with wrap, then pause
        hold(8'h09, 6);
        check("cnt_stable", stab, 8'h09);
        cyc(8'h09);
        check("cnt_entry", {4'd0, led},  8'h00);
        check("cnt_mode",  {6'd0, mode}, 8'h01);
        hold(8'h09, 2); cyc(8'h09);
        check("cnt_wrap", {4'd0, led}, 8'h0F);
        hold(8'h09, 2); cyc(8'h09);
        check("cnt_dec", {4'd0, led}, 8'h0E);
        hold(8'h0D, 6);
        check("pause_enter", {4'd0, led}, 8'h0C);
        hold(8'h0D, 20);
        check("pause_frozen", {4'd0, led}, 8'h0C);

        // SHIFT left, then direction flip with no reload
        hold(8'h02, 6);
        check("sh_stable", stab, 8'h02);
        cyc(8'h02);
        check("sh_entry", {4'd0, led},  8'h01);
        check("sh_mode",  {6'd0, mode}, 8'h02);
        hold(8'h02, 2); cyc(8'h02);
        check("sh_2", {4'd0, led}, 8'h02);
        hold(8'h02, 2); cyc(8'h02);
        check("sh_4", {4'd0, led}, 8'h04);
        cyc(8'h02);
        hold(8'h0A, 1); cyc(8'h0A);
        check("sh_8", {4'd0, led}, 8'h08);
        hold(8'h0A, 2); cyc(8'h0A);
        check("sh_wrap", {4'd0, led}, 8'h01);
        hold(8'h0A, 2); cyc(8'h0A);
        check("shr_8",      {4'd0, led}, 8'h08);
        check("shr_stable", stab,        8'h0A);
        hold(8'h0A, 2); cyc(8'h0A);
        check("shr_4",    {4'd0, led},  8'h04);
        check("shr_mode", {6'd0, mode}, 8'h02);

        // BLINK, then STATIC requested on a tick cycle
        hold(8'h53, 6);
        check("bl_stable", stab, 8'h53);
        cyc(8'h53);
        check("bl_entry", {4'd0, led},  8'h05);
        check("bl_mode",  {6'd0, mode}, 8'h03);
        hold(8'h53, 2);
        cyc(8'h50);
        check("bl_off", {4'd0, led}, 8'h00);
        hold(8'h50, 2); cyc(8'h50);
        check("bl_on", {4'd0, led}, 8'h05);
        cyc(8'h50);
        cyc(8'h50);
        check("bl_req_static", stab, 8'h50);
        cyc(8'h50);
        check("bl_tick_drop", {4'd0, led},  8'h05);
        check("bl_to_static", {6'd0, mode}, 8'h00);

        // reset in the middle of COUNT at 0111
        hold(8'h01, 6);
        cyc(8'h01);
        check("cu_mode", {6'd0, mode}, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            hold(8'h01, 2); cyc(8'h01);
            check("cu_step", {4'd0, led}, 8'(i));
        end
        step(8'h01, 1'b1);
        check("mid_rst_led",    {4'd0, led},  8'h00);
        check("mid_rst_mode",   {6'd0, mode}, 8'h00);
        check("mid_rst_stable", stab,         8'h00);
        hold(8'h01, 5);
        check("post_rst_early", stab, 8'h00);
        cyc(8'h01);
        check("post_rst_accept", stab, 8'h01);

        // randomized switch activity with occasional reset
        for (int k = 0; k < 80; k++) begin
            rs = 8'($urandom);
            n  = $urandom_range(1, 12);
            if ($urandom_range(0, 31) == 0) step(rs, 1'b1);
            hold(rs, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
